// File: rtl/plru_entry_alloc_ctrl.sv
// Allocation controller for a small fully-associative entry pool: round-robin grant,
// lowest-free / tree-PLRU victim selection, and an entry-by-entry flush sweep.
module plru_entry_alloc_ctrl #(
    parameter int ENTRY_COUNT_LOG2 = 3,
    parameter int REQ_COUNT        = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [REQ_COUNT-1:0]               alloc_req,
    output logic [REQ_COUNT-1:0]               alloc_gnt,
    output logic [ENTRY_COUNT_LOG2-1:0]        alloc_addr,
    output logic                               evict_valid,
    input  logic                               touch_en,
    input  logic [ENTRY_COUNT_LOG2-1:0]        touch_addr,
    input  logic                               free_en,
    input  logic [ENTRY_COUNT_LOG2-1:0]        free_addr,
    input  logic                               flush,
    output logic                               flush_evict_valid,
    output logic [ENTRY_COUNT_LOG2-1:0]        flush_evict_addr,
    output logic [(1<<ENTRY_COUNT_LOG2)-1:0]   occupied,
    output logic                               full,
    output logic                               ready
);
    localparam int L  = ENTRY_COUNT_LOG2;
    localparam int N  = 1 << L;
    localparam int RW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        occ_q, occ_d;
    logic [N-2:0]        plru_q, plru_d;
    logic [RW-1:0]       rr_q, rr_d;
    logic [L-1:0]        sweep_idx_q, sweep_idx_d;

    logic [L-1:0]        victim, free_victim, plru_victim;
    logic                any_free;
    logic                gnt_valid;
    int                  gnt_off;
    logic [RW:0]         gnt_sum;
    logic [RW-1:0]       gnt_idx;
    logic [2*REQ_COUNT-1:0] req_rot;

    // Every node on the path of entry e is made to point at the other subtree.
    function automatic logic [N-2:0] plru_touch(input logic [N-2:0] bits, input logic [L-1:0] e);
        logic [N-2:0] r;
        logic [31:0]  node;
        r    = bits;
        node = '0;
        for (int l = L-1; l >= 0; l--) begin
            r[node[L-1:0]] = ~e[l];
            node = 2*node + (e[l] ? 32'd2 : 32'd1);
        end
        return r;
    endfunction

    function automatic logic [L-1:0] plru_walk(input logic [N-2:0] bits);
        logic [31:0] node;
        node = '0;
        for (int l = 0; l < L; l++) begin
            node = 2*node + (bits[node[L-1:0]] ? 32'd2 : 32'd1);
        end
        node = node - 32'(N-1);
        return node[L-1:0];
    endfunction

    always_comb begin
        free_victim = '0;
        any_free    = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                any_free    = 1'b1;
                free_victim = L'(i);
            end
        end
        plru_victim = plru_walk(plru_q);
        victim      = any_free ? free_victim : plru_victim;
    end

    // Rotate requests so bit 0 is the requester at rr_q; the first set bit wins.
    always_comb begin
        req_rot   = {alloc_req, alloc_req} >> rr_q;
        gnt_valid = 1'b0;
        gnt_off   = 0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (!gnt_valid && req_rot[k]) begin
                gnt_valid = 1'b1;
                gnt_off   = k;
            end
        end
        gnt_valid = gnt_valid && (state_q == IDLE);
        gnt_sum   = {1'b0, rr_q} + (RW+1)'(gnt_off);
        if (gnt_sum >= (RW+1)'(REQ_COUNT)) begin
            gnt_sum = gnt_sum - (RW+1)'(REQ_COUNT);
        end
        gnt_idx   = gnt_sum[RW-1:0];
        alloc_gnt = gnt_valid ? (REQ_COUNT'(1) << gnt_idx) : '0;
    end

    always_comb begin
        plru_d = plru_q;
        if (touch_en) begin
            plru_d = plru_touch(plru_d, touch_addr);
        end
        if (gnt_valid) begin
            plru_d = plru_touch(plru_d, victim);
        end

        occ_d = occ_q;
        if (free_en) begin
            occ_d[free_addr] = 1'b0;
        end
        if (state_q == SWEEP) begin
            occ_d[sweep_idx_q] = 1'b0;
        end
        if (gnt_valid) begin
            occ_d[victim] = 1'b1;
        end

        rr_d = rr_q;
        if (gnt_valid) begin
            rr_d = (gnt_idx == RW'(REQ_COUNT-1)) ? '0 : gnt_idx + 1'b1;
        end

        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (state_q == IDLE) begin
            if (flush) begin
                state_d     = SWEEP;
                sweep_idx_d = '0;
            end
        end else begin
            sweep_idx_d = sweep_idx_q + 1'b1;
            if (sweep_idx_q == L'(N-1)) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            plru_q      <= '0;
            rr_q        <= '0;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            plru_q      <= plru_d;
            rr_q        <= rr_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    assign alloc_addr        = victim;
    assign evict_valid       = gnt_valid && !any_free;
    assign flush_evict_valid = (state_q == SWEEP) && occ_q[sweep_idx_q];
    assign flush_evict_addr  = sweep_idx_q;
    assign occupied          = occ_q;
    assign full              = &occ_q;
    assign ready             = (state_q == IDLE);

endmodule

// File: tb/tb_plru_entry_alloc_ctrl.sv
// Bench for plru_entry_alloc_ctrl with 4 entries and 2 requesters: a per-cycle
// reference model (half/quarter pointers) plus directed scenarios with literal checks.
module tb_plru_entry_alloc_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] alloc_req;
    logic [1:0] alloc_gnt;
    logic [1:0] alloc_addr;
    logic       evict_valid;
    logic       touch_en;
    logic [1:0] touch_addr;
    logic       free_en;
    logic [1:0] free_addr;
    logic       flush;
    logic       flush_evict_valid;
    logic [1:0] flush_evict_addr;
    logic [3:0] occupied;
    logic       full;
    logic       ready;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model: which half is older, and which entry within each half is older.
    int m_h;
    int m_sub [2];
    bit m_occ [4];
    int m_rr;
    bit m_sweep;
    int m_idx;

    plru_entry_alloc_ctrl #(.ENTRY_COUNT_LOG2(2), .REQ_COUNT(2)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
        .evict_valid(evict_valid),
        .touch_en(touch_en), .touch_addr(touch_addr),
        .free_en(free_en), .free_addr(free_addr),
        .flush(flush), .flush_evict_valid(flush_evict_valid),
        .flush_evict_addr(flush_evict_addr),
        .occupied(occupied), .full(full), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_h = 0; m_sub[0] = 0; m_sub[1] = 0;
        for (int i = 0; i < 4; i++) m_occ[i] = 0;
        m_rr = 0; m_sweep = 0; m_idx = 0;
    endtask

    task automatic m_touch(input int e);
        m_h        = (e < 2) ? 1 : 0;
        m_sub[e/2] = (e % 2 == 0) ? 1 : 0;
    endtask

    initial begin
        int  e_victim, e_gi, j;
        bit  e_anyfree;
        logic [1:0] e_gnt;
        logic [3:0] e_occ;
        m_reset();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_anyfree = 0;
                e_victim  = 0;
                for (int i = 3; i >= 0; i--) begin
                    if (!m_occ[i]) begin
                        e_anyfree = 1;
                        e_victim  = i;
                    end
                end
                if (!e_anyfree) e_victim = 2*m_h + m_sub[m_h];
                e_gi = -1;
                if (!m_sweep) begin
                    for (int k = 0; k < 2; k++) begin
                        j = (m_rr + k) % 2;
                        if (e_gi < 0 && alloc_req[j]) e_gi = j;
                    end
                end
                e_gnt = (e_gi >= 0) ? 2'(1 << e_gi) : 2'b00;
                e_occ = {m_occ[3], m_occ[2], m_occ[1], m_occ[0]};

                chk("m.alloc_gnt", 32'(alloc_gnt), 32'(e_gnt));
                if (e_gi >= 0) chk("m.alloc_addr", 32'(alloc_addr), 32'(e_victim));
                chk("m.evict_valid", 32'(evict_valid), 32'((e_gi >= 0) && !e_anyfree));
                chk("m.occupied", 32'(occupied), 32'(e_occ));
                chk("m.full", 32'(full), 32'(e_occ == 4'hf));
                chk("m.ready", 32'(ready), 32'(!m_sweep));
                chk("m.flush_evict_valid", 32'(flush_evict_valid), 32'(m_sweep && m_occ[m_idx]));
                if (m_sweep) chk("m.flush_evict_addr", 32'(flush_evict_addr), 32'(m_idx));

                if (reset) begin
                    m_reset();
                end else begin
                    if (touch_en) m_touch(int'(touch_addr));
                    if (e_gi >= 0) m_touch(e_victim);
                    if (free_en) m_occ[free_addr] = 0;
                    if (m_sweep) m_occ[m_idx] = 0;
                    if (e_gi >= 0) begin
                        m_occ[e_victim] = 1;
                        m_rr = (e_gi + 1) % 2;
                    end
                    if (!m_sweep) begin
                        if (flush) begin
                            m_sweep = 1;
                            m_idx   = 0;
                        end
                    end else if (m_idx == 3) begin
                        m_sweep = 0;
                        m_idx   = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit fev_exp [4];
        fev_exp[0] = 1; fev_exp[1] = 1; fev_exp[2] = 0; fev_exp[3] = 1;
        reset = 1; alloc_req = 0; touch_en = 0; touch_addr = 0;
        free_en = 0; free_addr = 0; flush = 0;
        nxt();
        chk_en = 1;
        nxt();
        reset = 0;
        @(negedge clk);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.flush_evict_valid", 32'(flush_evict_valid), 32'd0);
        chk("rst.alloc_gnt", 32'(alloc_gnt), 32'd0);
        chk("rst.occupied", 32'(occupied), 32'd0);

        // Fill from empty with one requester
        nxt();
        alloc_req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fill.gnt", 32'(alloc_gnt), 32'd1);
            chk("fill.addr", 32'(alloc_addr), 32'(i));
            chk("fill.evict", 32'(evict_valid), 32'd0);
            nxt();
        end
        alloc_req = 2'b00;
        @(negedge clk);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.occ", 32'(occupied), 32'hf);

        // PLRU victims once full
        nxt();
        alloc_req = 2'b01;
        @(negedge clk);
        chk("plru.addr0", 32'(alloc_addr), 32'd0);
        chk("plru.evict0", 32'(evict_valid), 32'd1);
        nxt();
        alloc_req = 2'b00; touch_en = 1; touch_addr = 2;
        nxt();
        touch_en = 0; alloc_req = 2'b01;
        @(negedge clk);
        chk("plru.addr1", 32'(alloc_addr), 32'd1);
        chk("plru.evict1", 32'(evict_valid), 32'd1);

        // Free plus grant in one cycle: victim unaffected by the free
        nxt();
        free_en = 1; free_addr = 2;
        @(negedge clk);
        chk("free.addr3", 32'(alloc_addr), 32'd3);
        chk("free.evict3", 32'(evict_valid), 32'd1);
        nxt();
        free_en = 0;
        @(negedge clk);
        chk("free.addr2", 32'(alloc_addr), 32'd2);
        chk("free.evict2", 32'(evict_valid), 32'd0);
        nxt();
        alloc_req = 2'b00; free_en = 1; free_addr = 2;
        nxt();
        free_en = 0; flush = 1;
        @(negedge clk);
        chk("sweep.pre_occ", 32'(occupied), 32'hb);
        nxt();
        flush = 0; alloc_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            flush = (i == 2);
            @(negedge clk);
            chk("sweep.fev", 32'(flush_evict_valid), 32'(fev_exp[i]));
            chk("sweep.faddr", 32'(flush_evict_addr), 32'(i));
            chk("sweep.gnt", 32'(alloc_gnt), 32'd0);
            chk("sweep.ready", 32'(ready), 32'd0);
            nxt();
        end
        flush = 0; alloc_req = 2'b00;
        @(negedge clk);
        chk("sweep.ready_after", 32'(ready), 32'd1);
        chk("sweep.occ_after", 32'(occupied), 32'd0);

        // Round-robin between two requesters from reset
        nxt();
        reset = 1;
        nxt();
        reset = 0; alloc_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr.gnt", 32'(alloc_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr.addr", 32'(alloc_addr), 32'(i));
            nxt();
        end
        alloc_req = 2'b00;

        // Reset in the second sweep cycle
        flush = 1;
        nxt();
        flush = 0;
        @(negedge clk);
        chk("rstsw.fev0", 32'(flush_evict_valid), 32'd1);
        nxt();
        reset = 1;
        @(negedge clk);
        chk("rstsw.faddr1", 32'(flush_evict_addr), 32'd1);
        nxt();
        reset = 0;
        @(negedge clk);
        chk("rstsw.ready", 32'(ready), 32'd1);
        chk("rstsw.occ", 32'(occupied), 32'd0);
        chk("rstsw.fev", 32'(flush_evict_valid), 32'd0);
        nxt();
        alloc_req = 2'b01;
        @(negedge clk);
        chk("rstsw.addr", 32'(alloc_addr), 32'd0);
        chk("rstsw.evict", 32'(evict_valid), 32'd0);

        // Touch and grant together: the grant path wins on the root node
        for (int i = 0; i < 4; i++) nxt();
        touch_en = 1; touch_addr = 3;
        @(negedge clk);
        chk("tg.addr0", 32'(alloc_addr), 32'd0);
        chk("tg.evict0", 32'(evict_valid), 32'd1);
        nxt();
        touch_en = 0;
        @(negedge clk);
        chk("tg.addr2", 32'(alloc_addr), 32'd2);
        nxt();
        free_en = 1; free_addr = 1;
        @(negedge clk);
        chk("tg.addr1", 32'(alloc_addr), 32'd1);
        nxt();
        free_en = 0; alloc_req = 2'b00;
        @(negedge clk);
        chk("tg.full_after_free_grant", 32'(full), 32'd1);

        nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/plru_entry_alloc_ctrl.md
Name: plru_entry_alloc_ctrl

Overview:
- Allocation controller for a small fully-associative entry pool, e.g. TLB or store-buffer entries. It shares the pool among several requesters.
- It tracks occupancy and tree pseudo-LRU state, and grants at most one allocation per cycle using round-robin arbitration.
- Victim choice: the lowest-index free entry if any exists, otherwise the PLRU victim.
- A flush sweep frees all entries, one per cycle, and reports each entry that was occupied.

Parameters:
- ENTRY_COUNT_LOG2, 3, log2 of entry count N. Legal range 1..5.
- REQ_COUNT, 2, number of allocation requesters. Legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alloc_req  input  REQ_COUNT  per-requester allocation request; level, held until granted.
- alloc_gnt  output  REQ_COUNT  one-hot grant, combinational, same cycle as request.
- alloc_addr  output  ENTRY_COUNT_LOG2  entry index allocated by the current grant.
- evict_valid  output  1  current grant replaces an occupied entry.
- touch_en  input  1  access-hit notification.
- touch_addr  input  ENTRY_COUNT_LOG2  entry index hit.
- free_en  input  1  release an entry.
- free_addr  input  ENTRY_COUNT_LOG2  entry index released.
- flush  input  1  single-cycle pulse; starts the sweep.
- flush_evict_valid  output  1  sweep is clearing an occupied entry this cycle.
- flush_evict_addr  output  ENTRY_COUNT_LOG2  index currently being swept.
- occupied  output  N  registered occupancy vector.
- full  output  1  all bits of occupied set.
- ready  output  1  high in IDLE.

Behaviour:
- Reset values: occupied=0; PLRU bits=0; rr_ptr=0; state=IDLE; sweep_idx=0.
  - Output consequences: ready=1, full=0, flush_evict_valid=0, alloc_gnt=0.
- PLRU tree:
  - N-1 bits. Node i has children 2i+1 and 2i+2; leaves map to entries in left-to-right order.
  - Victim walk: from the root, bit=0 goes left, bit=1 goes right.
  - Touch of entry e: every node on e's path is set to point away from e. Came from left sets the bit to 1; came from right sets it to 0.
  - With all bits 0 the victim is entry 0.
- Victim, combinational from current registers:
  - If any occupied bit is 0, the victim is the lowest free index and evict_valid=0.
  - Otherwise the victim is the PLRU victim and evict_valid=1 whenever a grant is issued.
- Arbitration, IDLE only:
  - Grant the first requester with alloc_req set, searching from rr_ptr upward with wrap-around.
  - alloc_addr = victim.
  - On the clock edge: occupied[victim]<=1, touch victim, rr_ptr<=granted+1 mod REQ_COUNT.
  - No requests: alloc_gnt=0, rr_ptr holds.
- Touch: applied every cycle touch_en=1, in IDLE or SWEEP.
  - Same cycle as a grant: touch_addr is applied first, then the grant-path update. The grant wins on shared nodes.
- Free: clears occupied[free_addr]. PLRU is unchanged.
  - Free and grant to the same index in the same cycle: the grant wins; the entry ends occupied.
  - A free takes effect next cycle only; it does not change the current victim.
  - Free of an entry already free: no effect.
- Flush FSM states: IDLE and SWEEP.
  - IDLE, flush=1: go to SWEEP with sweep_idx=0. A grant in the same cycle is still honoured.
  - SWEEP, each cycle:
    - flush_evict_addr=sweep_idx and flush_evict_valid=occupied[sweep_idx].
    - Clear occupied[sweep_idx], then increment sweep_idx.
    - alloc_gnt=0 and ready=0.
    - flush=1 is ignored.
    - free_en is still honoured.
  - SWEEP with sweep_idx=N-1: return to IDLE next cycle. The sweep takes exactly N cycles.
  - PLRU bits are not reset by flush.
- Reset mid-sweep: back to IDLE with all state at reset values.
- full and occupied reflect registered state only.

Test Plan:
1. N=4, REQ_COUNT=2. After reset, hold alloc_req=01 for 4 cycles -> alloc_addr 0,1,2,3; evict_valid=0; full=1 on the next cycle.
2. Continue from 1 (PLRU bits node0=0, node1=0, node2=0), request once more -> alloc_addr=0, evict_valid=1. Then touch_en on entry 2 plus a request -> victim 1, grant addr 1.
3. alloc_req=11 held for 4 cycles from reset -> alloc_gnt sequence 01,10,01,10; addrs 0,1,2,3.
4. With full=1, free_addr=2 and a request in the same cycle -> grant PLRU victim with evict_valid=1. Next cycle's request -> alloc_addr=2, evict_valid=0.
5. Occupied=1011, pulse flush -> 4 cycles of SWEEP: flush_evict_valid 1,1,0,1 at addrs 0,1,2,3; alloc_gnt=0 and ready=0 throughout; then ready=1 and occupied=0000.
6. Assert reset during the second SWEEP cycle -> next cycle IDLE, occupied=0, flush_evict_valid=0, victim=0.
